multicycle_sequencer: RTL
=========================

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 Parameter WAIT_LIMIT, default 15, max idle-ready cycles tolerated in FETCH/MEMORY before fault.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 start  in  1  begin sequencing; sampled only in IDLE.
REQ-005 halt  in  1  stop after current instruction; sampled only in WRITEBACK.
REQ-006 opcode  in  7  instruction[6:0] from instruction register.
REQ-007 imem_ready  in  1  instruction memory data valid.
REQ-008 dmem_ready  in  1  data memory access complete.
REQ-009 imem_rEn  out  1  instruction read request.
REQ-010 ir_load  out  1  latch instruction register.
REQ-011 dmem_rEn  out  1  data read request (loads).
REQ-012 mem_wEn_gate  out  1  enables decode mem_wEn to memory (stores).
REQ-013 rf_wEn_gate  out  1  enables decode wEn to register file.
REQ-014 pc_wEn  out  1  commit next PC (next_PC_select/target_PC) to fetch.
REQ-015 retired  out  1  one-cycle pulse per completed instruction.
REQ-016 fault  out  1  sticky error indication.
REQ-017 state  out  3  current state encoding.
REQ-018 cycle_count, instret_count  out  32 each  performance counters.

Function
REQ-019 States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, FAULT; all outputs except counters are Moore, decoded from the state register.
REQ-020 IDLE: start=1 -> FETCH; else stay.
REQ-021 FETCH: imem_rEn=1; imem_ready=1 -> ir_load=1 same cycle, -> DECODE.
REQ-022 DECODE: one cycle, -> EXECUTE.
REQ-023 EXECUTE: one cycle; opcode LOAD(0000011)/STORE(0100011) -> MEMORY; R/I/BRANCH/JAL/JALR/AUIPC/LUI -> WRITEBACK; any other opcode -> FAULT.
REQ-024 MEMORY: dmem_rEn=1 for LOAD, mem_wEn_gate=1 for STORE, held until dmem_ready=1, then -> WRITEBACK.
REQ-025 WRITEBACK: pc_wEn=1, retired=1, rf_wEn_gate=1; halt=1 -> IDLE, else -> FETCH.
REQ-026 FAULT: fault=1, all enables 0; exit only via reset.
REQ-027 Wait counter cleared on entry to FETCH/MEMORY; each waiting cycle: ready=1 advances (priority), else counter==WAIT_LIMIT -> FAULT, else counter+1; max WAIT_LIMIT+1 cycles in state.
REQ-028 Counter width clog2(WAIT_LIMIT+1); WAIT_LIMIT=0 means ready required on first cycle.
REQ-029 Minimum latency: ALU/branch/jump 4 cycles, load/store 5 cycles, start edge to first retired.
REQ-030 start outside IDLE and halt outside WRITEBACK have no effect.
REQ-031 No enable output asserted in more than one state; mem_wEn_gate and dmem_rEn never both 1.

Reset
REQ-032 reset -> IDLE, wait counter 0, all 1-bit outputs 0, cycle_count/instret_count 0.
REQ-033 reset mid-instruction (any state incl. MEMORY with store pending) drops all enables the following cycle; no partial retire.

Configuration
REQ-034 Macro SEQ_PERF_COUNTERS_EN defined: cycle_count +1 every cycle state not IDLE/FAULT; instret_count +1 per retired pulse; both wrap modulo 2^32.
REQ-035 Macro undefined: counter registers absent, ports present and driven constant 0.

Structure
REQ-036 Shared package core_pkg holds state encodings (IDLE=0..FAULT=6) and opcode constants identical to those used by decode.
REQ-037 One sub-module wait_timer (clear, count enable, expire flag, parameter WAIT_LIMIT) implements REQ-027.

Verification
REQ-038 reset, start=1, imem_ready=1, opcode=0110011, halt=1 -> retired at cycle 4, rf_wEn_gate=1 only that cycle, then IDLE.
REQ-039 opcode=0000011, dmem_ready low 3 cycles -> dmem_rEn=1 for 4 cycles, retired at cycle 8.
REQ-040 WAIT_LIMIT=15, imem_ready held 0 -> FAULT after 16 FETCH cycles, fault=1 until reset.
REQ-041 opcode=1111111 in EXECUTE -> FAULT next cycle, no pc_wEn, no retired.
REQ-042 reset asserted in MEMORY with STORE -> mem_wEn_gate=0 next cycle, state=IDLE, counters 0.
REQ-043 SEQ_PERF_COUNTERS_EN, 3 back-to-back ALU instructions -> instret_count=3, cycle_count=12; without macro both 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: sequencer state encodings and RV32 base opcodes.
// The opcode constants here are the same ones the decode stage uses, so the
// sequencer's notion of a legal instruction class never drifts from decode.
package core_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    FAULT     = 3'd6
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Instructions that need a data-memory access before writeback.
  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  // Instructions that go straight from EXECUTE to WRITEBACK.
  function automatic logic is_direct_op(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Wait timer for the memory-handshake states.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   clear        : force the count to zero
//   count_en     : one more cycle spent waiting for ready
//   expired      : count has reached WAIT_LIMIT
// WAIT_LIMIT = 0 makes expired true immediately, i.e. ready is required on
// the first waiting cycle.
module wait_timer #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

  logic [CW-1:0] count_q;

  assign expired = (count_q == LIMIT);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (count_en && !expired) begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: IDLE -> FETCH -> DECODE -> EXECUTE ->
// [MEMORY] -> WRITEBACK, with a sticky FAULT on illegal opcode or a memory
// handshake that never completes within WAIT_LIMIT+1 cycles.
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   start                   : begin sequencing (IDLE only)
//   halt                    : return to IDLE after this instruction (WRITEBACK only)
//   opcode                  : instruction[6:0] from the instruction register
//   imem_ready, dmem_ready  : memory handshakes
//   imem_rEn, ir_load       : instruction fetch request / IR latch
//   dmem_rEn, mem_wEn_gate  : data read request / store write gate
//   rf_wEn_gate, pc_wEn     : register-file write gate / PC commit
//   retired, fault          : per-instruction pulse / sticky error
//   state                   : current state encoding
//   cycle_count, instret_count : performance counters
// Build option: SEQ_PERF_COUNTERS_EN enables the performance counters;
// without it the counter ports are tied to zero.
module multicycle_sequencer
  import core_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        halt,
  input  logic [6:0]  opcode,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_rEn,
  output logic        ir_load,
  output logic        dmem_rEn,
  output logic        mem_wEn_gate,
  output logic        rf_wEn_gate,
  output logic        pc_wEn,
  output logic        retired,
  output logic        fault,
  output logic [2:0]  state,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
);

  state_t state_q, state_d;
  logic   mem_is_store_q;
  logic   in_wait, wait_ready, wait_expired;

  // Load/store kind is captured in EXECUTE so the MEMORY enables depend only
  // on registered state, not on the live opcode input.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      mem_is_store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == EXECUTE) begin
        mem_is_store_q <= (opcode == OP_STORE);
      end
    end
  end

  assign in_wait    = (state_q == FETCH) || (state_q == MEMORY);
  assign wait_ready = (state_q == FETCH) ? imem_ready : dmem_ready;

  // FETCH and MEMORY are only ever entered from other states, so holding the
  // timer clear outside them is equivalent to clearing it on entry.
  wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_wait_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (!in_wait),
    .count_en (in_wait && !wait_ready),
    .expired  (wait_expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start) state_d = FETCH;
      FETCH:     if (imem_ready) state_d = DECODE;
                 else if (wait_expired) state_d = FAULT;
      DECODE:    state_d = EXECUTE;
      EXECUTE:   if (is_mem_op(opcode)) state_d = MEMORY;
                 else if (is_direct_op(opcode)) state_d = WRITEBACK;
                 else state_d = FAULT;
      MEMORY:    if (dmem_ready) state_d = WRITEBACK;
                 else if (wait_expired) state_d = FAULT;
      WRITEBACK: state_d = halt ? IDLE : FETCH;
      FAULT:     state_d = FAULT;
      default:   state_d = FAULT;
    endcase
  end

  always_comb begin
    imem_rEn     = 1'b0;
    ir_load      = 1'b0;
    dmem_rEn     = 1'b0;
    mem_wEn_gate = 1'b0;
    rf_wEn_gate  = 1'b0;
    pc_wEn       = 1'b0;
    retired      = 1'b0;
    fault        = 1'b0;
    case (state_q)
      FETCH: begin
        imem_rEn = 1'b1;
        ir_load  = imem_ready;
      end
      MEMORY: begin
        dmem_rEn     = !mem_is_store_q;
        mem_wEn_gate = mem_is_store_q;
      end
      WRITEBACK: begin
        rf_wEn_gate = 1'b1;
        pc_wEn      = 1'b1;
        retired     = 1'b1;
      end
      FAULT:   fault = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

`ifdef SEQ_PERF_COUNTERS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      if (state_q != IDLE && state_q != FAULT) begin
        cycle_count <= cycle_count + 32'd1;
      end
      if (retired) begin
        instret_count <= instret_count + 32'd1;
      end
    end
  end
`else
  assign cycle_count   = '0;
  assign instret_count = '0;
`endif

endmodule
